// File: rtl/fifo_wr_arb_pkg.sv
// Shared types, defaults and helpers for the FIFO write-port arbiter and its round-robin picker.
package fifo_wr_arb_pkg;

    localparam int unsigned DEF_DW    = 8;
    localparam int unsigned DEF_NREQ  = 4;
    localparam int unsigned DEF_BURST = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // Next round-robin pointer after index ptr, wrapping to 0 past nreq-1.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned nreq);
        return (ptr + 1 >= nreq) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above i_ptr, wrapping around.
module rr_pick
    import fifo_wr_arb_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ,
    parameter int unsigned IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IW-1:0]   i_ptr,
    output logic            o_found,
    output logic [IW-1:0]   o_idx
);

    always_comb begin
        int unsigned w_j;
        o_found = 1'b0;
        o_idx   = '0;
        w_j     = 0;
        // Walk offsets downward so the smallest offset from i_ptr wins.
        for (int i = NREQ - 1; i >= 0; i--) begin
            w_j = 32'(i_ptr) + unsigned'(i);
            if (w_j >= NREQ) begin
                w_j = w_j - NREQ;
            end
            if (i_req[w_j[IW-1:0]]) begin
                o_found = 1'b1;
                o_idx   = w_j[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one fifo_sync write port among NREQ stream sources.
// Define FIFO_WR_ARB_PKT_LOCK_EN to hold each grant until end of packet instead of BURST words.
module fifo_wr_arbiter
    import fifo_wr_arb_pkg::*;
#(
    parameter int unsigned DW    = DEF_DW,
    parameter int unsigned NREQ  = DEF_NREQ,
    parameter int unsigned BURST = DEF_BURST,
    parameter int unsigned IW    = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NREQ-1:0]    req_en,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ-1:0]    req_last,
    output logic [NREQ-1:0]    req_rdy,
    output logic               o_en,
    output logic [DW-1:0]      o_data,
    input  logic               o_rdy,
    output logic [IW-1:0]      gnt_id,
    output logic               busy
);

    localparam int unsigned   CW        = $clog2(BURST) + 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);

    state_e        r_state;
    logic [IW-1:0] r_gnt_id;
    logic [IW-1:0] r_rr_ptr;
    logic [CW-1:0] r_beat_cnt;

    logic          w_found;
    logic [IW-1:0] w_pick;
    logic          w_grant;
    logic          w_src_en;
    logic          w_xfer;
    logic          w_burst_end;
    logic          w_release;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .i_req   (req_en),
        .i_ptr   (r_rr_ptr),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    assign w_grant  = (r_state == ST_GRANT);
    assign w_src_en = req_en[r_gnt_id];
    assign w_xfer   = o_en & o_rdy;

`ifdef FIFO_WR_ARB_PKT_LOCK_EN
    assign w_burst_end = 1'b0;
`else
    assign w_burst_end = (r_beat_cnt == LAST_BEAT);
`endif

    // A source bubble releases even while the FIFO is full.
    assign w_release = w_grant & (~w_src_en | (w_xfer & (req_last[r_gnt_id] | w_burst_end)));

    always_comb begin
        o_en    = w_grant & w_src_en;
        o_data  = '0;
        req_rdy = '0;
        for (int k = 0; k < int'(NREQ); k++) begin
            if (w_grant && (r_gnt_id == IW'(k))) begin
                o_data     = req_data[k*DW +: DW];
                req_rdy[k] = o_rdy;
            end
        end
    end

    assign gnt_id = r_gnt_id;
    assign busy   = w_grant;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_gnt_id   <= '0;
            r_rr_ptr   <= '0;
            r_beat_cnt <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_gnt_id   <= w_pick;
                        r_beat_cnt <= '0;
                        r_state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (w_xfer) begin
`ifdef FIFO_WR_ARB_PKT_LOCK_EN
                        if (r_beat_cnt != LAST_BEAT) begin
                            r_beat_cnt <= r_beat_cnt + CW'(1);
                        end
`else
                        r_beat_cnt <= r_beat_cnt + CW'(1);
`endif
                    end
                    if (w_release) begin
                        r_state  <= ST_IDLE;
                        r_rr_ptr <= IW'(rr_next(32'(r_gnt_id), NREQ));
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: source word queues feed the DUT, expected words are
// queued per scenario and popped on every observed transfer.
module tb_fifo_wr_arbiter;

    localparam int DW    = 8;
    localparam int NREQ  = 4;
    localparam int BURST = 16;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic [NREQ-1:0]   req_en = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0]   req_last = '0;
    logic [NREQ-1:0]   req_rdy;
    logic              o_en;
    logic [DW-1:0]     o_data;
    logic              o_rdy = 1'b1;
    logic [1:0]        gnt_id;
    logic              busy;

    fifo_wr_arbiter #(
        .DW    (DW),
        .NREQ  (NREQ),
        .BURST (BURST)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .req_en   (req_en),
        .req_data (req_data),
        .req_last (req_last),
        .req_rdy  (req_rdy),
        .o_en     (o_en),
        .o_data   (o_data),
        .o_rdy    (o_rdy),
        .gnt_id   (gnt_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Source model: word = {last, data}; data encodes source id and word index.
    logic [8:0]  mem [NREQ][64];
    int          len [NREQ];
    int          ptr [NREQ];
    logic [3:0]  mask;
    logic        rdy_v;

    logic [9:0]  sb [$];
    int          glog [$];
    int          blog [$];
    int          gaps [$];
    int          idle_run;
    logic        prev_busy;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic load_src(input int k, input int n, input int last_a, input int last_b);
        len[k] = n;
        ptr[k] = 0;
        for (int i = 0; i < n; i++) begin
            mem[k][i] = {(i == last_a) || (i == last_b), 8'(k * 64 + i)};
        end
    endtask

    task automatic push_exp(input int k, input int from, input int to);
        for (int i = from; i <= to; i++) begin
            sb.push_back({2'(k), 8'(k * 64 + i)});
        end
    endtask

    task automatic clear_all();
        sb.delete();
        glog.delete();
        blog.delete();
        gaps.delete();
        idle_run  = 0;
        prev_busy = 1'b0;
        mask      = 4'hf;
        rdy_v     = 1'b1;
        for (int k = 0; k < NREQ; k++) begin
            len[k] = 0;
            ptr[k] = 0;
        end
    endtask

    task automatic drive();
        o_rdy = rdy_v;
        for (int k = 0; k < NREQ; k++) begin
            req_en[k]            = mask[k] && (ptr[k] < len[k]);
            req_data[k*DW +: DW] = mem[k][ptr[k]][7:0];
            req_last[k]          = req_en[k] && mem[k][ptr[k]][8];
        end
    endtask

    task automatic sample();
        logic [9:0] e;
        chk("rdy_onehot0", 32'($onehot0(req_rdy)), 1);
        if (!o_rdy) chk("rdy_while_full", 32'(req_rdy), 0);
        if (busy && !prev_busy) begin
            glog.push_back(int'(gnt_id));
            blog.push_back(0);
            gaps.push_back(idle_run);
            idle_run = 0;
        end
        if (!busy) idle_run++;
        prev_busy = busy;
        if (o_en && o_rdy) begin
            if (sb.size() == 0) begin
                chk("unexpected_xfer", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                chk("xfer_data", 32'({gnt_id, o_data}), 32'(e));
            end
            if (blog.size() > 0) blog[blog.size()-1] = blog[blog.size()-1] + 1;
            if (ptr[gnt_id] < len[gnt_id]) ptr[gnt_id]++;
        end
    endtask

    task automatic step();
        @(negedge clk);
        drive();
        #1;
        sample();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rstn = 1'b0;
        clear_all();
        drive();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk(tag, sb.size(), 0);
        repeat (3) step();
    endtask

    initial begin
        int n;
        clear_all();
        drive();
        #1;
        chk("rst_o_en", 32'(o_en), 0);
        chk("rst_req_rdy", 32'(req_rdy), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_gnt_id", 32'(gnt_id), 0);
        chk("rst_o_data", 32'(o_data), 0);

        // Single source 2, 20 words: 16-beat burst, one idle, then 4 beats.
        apply_reset();
        load_src(2, 20, -1, -1);
        push_exp(2, 0, 19);
        drain("t1_drain", 100);
        chk("t1_ngrants", glog.size(), 2);
        if (glog.size() == 2) begin
            chk("t1_gnt0", glog[0], 2);
            chk("t1_gnt1", glog[1], 2);
            chk("t1_beats0", blog[0], 16);
            chk("t1_beats1", blog[1], 4);
            chk("t1_gap", gaps[1], 1);
        end

        // All four sources busy: rotation 0,1,2,3,0,1,2,3.
        apply_reset();
        for (int k = 0; k < NREQ; k++) load_src(k, 20, -1, -1);
        for (int k = 0; k < NREQ; k++) push_exp(k, 0, 15);
        for (int k = 0; k < NREQ; k++) push_exp(k, 16, 19);
        drain("t2_drain", 300);
        chk("t2_ngrants", glog.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < glog.size()) begin
                chk("t2_gnt", glog[i], i % 4);
                chk("t2_beats", blog[i], (i < 4) ? 16 : 4);
                if (i > 0) chk("t2_gap", gaps[i], 1);
            end
        end

        // FIFO full for 10 cycles at beat 5 of source 1.
        apply_reset();
        load_src(1, 20, -1, -1);
        push_exp(1, 0, 19);
        n = 0;
        while (!(blog.size() == 1 && blog[0] == 5) && n < 50) begin
            step();
            n++;
        end
        chk("t3_reach5", (blog.size() > 0) ? blog[0] : 0, 5);
        rdy_v = 1'b0;
        repeat (10) begin
            step();
            chk("t3_hold_en", 32'(o_en), 1);
            chk("t3_hold_busy", 32'(busy), 1);
        end
        chk("t3_frozen", (blog.size() > 0) ? blog[0] : 0, 5);
        rdy_v = 1'b1;
        drain("t3_drain", 100);
        chk("t3_ngrants", glog.size(), 2);
        if (glog.size() == 2) begin
            chk("t3_beats0", blog[0], 16);
            chk("t3_beats1", blog[1], 4);
        end

        // Source 0 ends a packet on word 3 (index 2); source 1 gets the next grant.
        apply_reset();
        load_src(0, 6, 2, 5);
        load_src(1, 4, 3, -1);
        push_exp(0, 0, 2);
        push_exp(1, 0, 3);
        push_exp(0, 3, 5);
        drain("t4_drain", 100);
        chk("t4_ngrants", glog.size(), 3);
        if (glog.size() == 3) begin
            chk("t4_gnt1", glog[1], 1);
            chk("t4_gnt2", glog[2], 0);
            chk("t4_beats0", blog[0], 3);
            chk("t4_beats1", blog[1], 4);
        end

        // Source 3 drops req_en after two words: pointer wraps to 0, source 1 next.
        apply_reset();
        mask = 4'b1000;
        load_src(3, 6, -1, -1);
        load_src(1, 2, -1, -1);
        load_src(2, 2, -1, -1);
        push_exp(3, 0, 1);
        push_exp(1, 0, 1);
        push_exp(2, 0, 1);
        push_exp(3, 2, 5);
        n = 0;
        while (ptr[3] < 2 && n < 30) begin
            step();
            n++;
        end
        mask = 4'b0110;
        step();
        chk("t5_drop_no_xfer", ptr[3], 2);
        mask = 4'b1110;
        drain("t5_drain", 100);
        chk("t5_ngrants", glog.size(), 4);
        if (glog.size() == 4) begin
            chk("t5_gnt0", glog[0], 3);
            chk("t5_gnt1", glog[1], 1);
            chk("t5_gnt2", glog[2], 2);
            chk("t5_gnt3", glog[3], 3);
            chk("t5_beats0", blog[0], 2);
        end

        // Asynchronous reset during beat 7 of source 2.
        apply_reset();
        load_src(2, 20, -1, -1);
        push_exp(2, 0, 19);
        n = 0;
        while (ptr[2] < 7 && n < 30) begin
            step();
            n++;
        end
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("t6_o_en", 32'(o_en), 0);
        chk("t6_req_rdy", 32'(req_rdy), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_gnt_id", 32'(gnt_id), 0);
        step();
        step();
        rstn = 1'b1;
        drain("t6_drain", 100);
        chk("t6_ngrants", glog.size(), 2);
        if (glog.size() == 2) begin
            chk("t6_beats0", blog[0], 7);
            chk("t6_beats1", blog[1], 13);
        end

`ifdef FIFO_WR_ARB_PKT_LOCK_EN
        // A 40-word packet stays contiguous even with another source waiting.
        apply_reset();
        load_src(1, 40, 39, -1);
        load_src(2, 5, 4, -1);
        push_exp(1, 0, 39);
        push_exp(2, 0, 4);
        drain("t7_drain", 200);
        chk("t7_ngrants", glog.size(), 2);
        if (glog.size() == 2) begin
            chk("t7_gnt0", glog[0], 1);
            chk("t7_beats0", blog[0], 40);
            chk("t7_gnt1", glog[1], 2);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
